// File: rtl/cond_defs_pkg.sv
// rtl/cond_defs_pkg.sv - condition codes and flag bit positions for the execute stage
package cond_defs;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational evaluation of a condition field against NZCV
module cond_check
  import cond_defs::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       ce_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    ce_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: ce_o = z;
      COND_NE: ce_o = ~z;
      COND_CS: ce_o = c;
      COND_CC: ce_o = ~c;
      COND_MI: ce_o = n;
      COND_PL: ce_o = ~n;
      COND_VS: ce_o = v;
      COND_VC: ce_o = ~v;
      COND_HI: ce_o = c & ~z;
      COND_LS: ce_o = ~c | z;
      COND_GE: ce_o = (n == v);
      COND_LT: ce_o = (n != v);
      COND_GT: ce_o = ~z & (n == v);
      COND_LE: ce_o = z | (n != v);
      COND_AL: ce_o = 1'b1;
      COND_NV: ce_o = 1'b0;
      default: ce_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cond_stage.sv
// rtl/exec_cond_stage.sv - execute-to-writeback stage with NZCV register and condition gating
module exec_cond_stage
  import cond_defs::*;
#(
  parameter int N    = 4,
  parameter int RA_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N-1:0]    result_i,
  input  logic [3:0]      alu_flags_i,
  input  logic [3:0]      cond_i,
  input  logic [1:0]      flag_w_i,
  input  logic            reg_w_i,
  input  logic            mem_w_i,
  input  logic            pc_s_i,
  input  logic [RA_W-1:0] rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [N-1:0]    result_o,
  output logic [RA_W-1:0] rd_o,
  output logic            reg_w_o,
  output logic            mem_w_o,
  output logic            pc_src_o,
  output logic            cond_ex_o,
  output logic [3:0]      flags_o
);

  logic ce;
  logic accept;

  // Condition sees the flags left by earlier instructions, not this one's ALU flags.
  cond_check u_cond_check (
    .cond_i  (cond_i),
    .flags_i (flags_o),
    .ce_o    (ce)
  );

  assign in_ready_o = ~flush_i & (~out_valid_o | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      rd_o        <= '0;
      reg_w_o     <= 1'b0;
      mem_w_o     <= 1'b0;
      pc_src_o    <= 1'b0;
      cond_ex_o   <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      result_o    <= result_i;
      rd_o        <= rd_i;
      reg_w_o     <= reg_w_i & ce;
      mem_w_o     <= mem_w_i & ce;
      pc_src_o    <= pc_s_i & ce;
      cond_ex_o   <= ce;
    end else if (flush_i || out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flags_o <= 4'b0000;
    end else if (accept && ce) begin
      if (flag_w_i[FW_NZ]) begin
        flags_o[FLAG_N] <= alu_flags_i[FLAG_N];
        flags_o[FLAG_Z] <= alu_flags_i[FLAG_Z];
      end
      if (flag_w_i[FW_CV]) begin
        flags_o[FLAG_C] <= alu_flags_i[FLAG_C];
        flags_o[FLAG_V] <= alu_flags_i[FLAG_V];
      end
    end
  end

endmodule

// File: tb/tb_exec_cond_stage.sv
// tb/tb_exec_cond_stage.sv - directed and randomized checks of exec_cond_stage against a reference model
module tb_exec_cond_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, in_valid, in_ready;
  logic [3:0] result_in, alu_flags, cond, rd_in;
  logic [1:0] flag_w;
  logic       reg_w_in, mem_w_in, pc_s_in;
  logic       out_valid, out_ready;
  logic [3:0] result_out, rd_out, flags;
  logic       reg_w_out, mem_w_out, pc_src_out, cond_ex;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  bit       m_valid;
  bit [3:0] m_result, m_rd, m_flags;
  bit       m_regw, m_memw, m_pc, m_ce;

  exec_cond_stage #(.N(4), .RA_W(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .result_i    (result_in),
    .alu_flags_i (alu_flags),
    .cond_i      (cond),
    .flag_w_i    (flag_w),
    .reg_w_i     (reg_w_in),
    .mem_w_i     (mem_w_in),
    .pc_s_i      (pc_s_in),
    .rd_i        (rd_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result_out),
    .rd_o        (rd_out),
    .reg_w_o     (reg_w_out),
    .mem_w_o     (mem_w_out),
    .pc_src_o    (pc_src_out),
    .cond_ex_o   (cond_ex),
    .flags_o     (flags)
  );

  always #5 clk = ~clk;

  // Conditions come in pairs: even code tests a predicate, odd code its inverse.
  function automatic bit ref_cond(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v, p;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: p = z;
      3'd1: p = cy;
      3'd2: p = n;
      3'd3: p = v;
      3'd4: p = cy && !z;
      3'd5: p = (n == v);
      3'd6: p = !z && (n == v);
      default: p = 1'b1;
    endcase
    return c[0] ? !p : p;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_result = 0; m_rd = 0; m_flags = 0;
    m_regw = 0; m_memw = 0; m_pc = 0; m_ce = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
    chk("flags", {4'd0, flags}, {4'd0, m_flags});
    if (m_valid) begin
      chk("result", {4'd0, result_out}, {4'd0, m_result});
      chk("rd", {4'd0, rd_out}, {4'd0, m_rd});
      chk("gates", {4'd0, reg_w_out, mem_w_out, pc_src_out, cond_ex},
                   {4'd0, m_regw, m_memw, m_pc, m_ce});
    end
  endtask

  // Called with inputs already driven, shortly after a rising edge.
  task automatic cycle();
    bit rdy, acc, ce;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    chk("in_ready", {7'd0, in_ready}, {7'd0, rdy});
    acc = in_valid && rdy;
    ce  = ref_cond(cond, m_flags);
    @(posedge clk);
    if (acc) begin
      m_valid = 1; m_result = result_in; m_rd = rd_in;
      m_regw = reg_w_in && ce; m_memw = mem_w_in && ce; m_pc = pc_s_in && ce; m_ce = ce;
      if (ce && flag_w[1]) m_flags[3:2] = alu_flags[3:2];
      if (ce && flag_w[0]) m_flags[1:0] = alu_flags[1:0];
    end else if (flush || out_ready) begin
      m_valid = 0;
    end
    #1;
    check_outputs();
  endtask

  task automatic pkt(input bit [3:0] c, input bit [1:0] fw, input bit [3:0] af,
                     input bit [3:0] res, input bit [3:0] rd, input bit rw, input bit mw, input bit ps);
    in_valid = 1; cond = c; flag_w = fw; alu_flags = af;
    result_in = res; rd_in = rd; reg_w_in = rw; mem_w_in = mw; pc_s_in = ps;
    cycle();
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    result_in = 0; alu_flags = 0; cond = 0; rd_in = 0; flag_w = 0;
    reg_w_in = 0; mem_w_in = 0; pc_s_in = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {7'd0, out_valid}, 8'd0);
    chk("reset_flags", {4'd0, flags}, 8'd0);
    rst_n = 1;

    // 1: EQ fails on cleared flags, packet still valid with writes gated off
    pkt(4'h0, 2'b00, 4'h0, 4'h5, 4'h3, 1, 0, 0);
    chk("t1_gates", {4'd0, result_out, 1'b0, reg_w_out, cond_ex, out_valid}, {4'd0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("t1_rd", {4'd0, rd_out}, 8'd3);

    // 2: set Z then EQ passes
    pkt(4'hE, 2'b11, 4'b0100, 4'h0, 4'h1, 0, 0, 0);
    chk("t2_flags", {4'd0, flags}, 8'b0100);
    pkt(4'h0, 2'b00, 4'h0, 4'h9, 4'h2, 1, 1, 0);
    chk("t2_gates", {5'd0, reg_w_out, mem_w_out, cond_ex}, 8'b111);

    // 3: partial flag updates
    pkt(4'hE, 2'b11, 4'b0011, 4'h0, 4'h0, 0, 0, 0);
    pkt(4'hE, 2'b10, 4'b1000, 4'h0, 4'h0, 0, 0, 0);
    chk("t3_nz_only", {4'd0, flags}, 8'b1011);
    pkt(4'hE, 2'b01, 4'b0000, 4'h0, 4'h0, 0, 0, 0);
    chk("t3_cv_only", {4'd0, flags}, 8'b1000);

    // 4: signed conditions with N=1 V=0, then N=1 V=1 Z=0
    pkt(4'hB, 2'b00, 4'h0, 4'h1, 4'h1, 1, 0, 0); chk("t4_lt", {7'd0, cond_ex}, 8'd1);
    pkt(4'hA, 2'b00, 4'h0, 4'h1, 4'h1, 1, 0, 0); chk("t4_ge", {7'd0, cond_ex}, 8'd0);
    pkt(4'hD, 2'b00, 4'h0, 4'h1, 4'h1, 1, 0, 0); chk("t4_le", {7'd0, cond_ex}, 8'd1);
    pkt(4'hC, 2'b00, 4'h0, 4'h1, 4'h1, 1, 0, 0); chk("t4_gt", {7'd0, cond_ex}, 8'd0);
    pkt(4'hE, 2'b11, 4'b1001, 4'h0, 4'h0, 0, 0, 0);
    pkt(4'hC, 2'b00, 4'h0, 4'h1, 4'h1, 0, 0, 1); chk("t4_gt_pass", {6'd0, pc_src_out, cond_ex}, 8'b11);
    pkt(4'hF, 2'b11, 4'b0000, 4'h1, 4'h1, 1, 1, 1);
    chk("t4_never", {4'd0, reg_w_out, mem_w_out, pc_src_out, cond_ex}, 8'd0);
    chk("t4_never_flags", {4'd0, flags}, 8'b1001);

    // 5: backpressure holds output and flags
    out_ready = 0;
    in_valid = 1; cond = 4'hE; flag_w = 2'b11; alu_flags = 4'hF; result_in = 4'hA; rd_in = 4'h7;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_stall_ready", {7'd0, in_ready}, 8'd0);
      chk("t5_stall_flags", {4'd0, flags}, 8'b1001);
    end
    out_ready = 1;
    cycle();
    chk("t5_release_flags", {4'd0, flags}, 8'hF);

    // 6: flush beats a valid input, then async reset mid-packet
    flush = 1; alu_flags = 4'h0;
    cycle();
    chk("t6_flush_valid", {7'd0, out_valid}, 8'd0);
    chk("t6_flush_flags", {4'd0, flags}, 8'hF);
    flush = 0;
    pkt(4'hE, 2'b00, 4'h0, 4'hC, 4'h5, 1, 1, 1);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("t6_async_reset", {out_valid, reg_w_out, mem_w_out, pc_src_out, cond_ex, 3'd0}, 8'd0);
    chk("t6_async_data", {result_out, rd_out}, 8'd0);
    chk("t6_async_flags", {4'd0, flags}, 8'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 9) == 0);
      cond      = 4'($urandom);
      flag_w    = 2'($urandom);
      alu_flags = 4'($urandom);
      result_in = 4'($urandom);
      rd_in     = 4'($urandom);
      reg_w_in  = 1'($urandom);
      mem_w_in  = 1'($urandom);
      pc_s_in   = 1'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
